// File: rtl/hdmi_frame_decimator.sv
// HDMI input conditioning: run-time frame decimation, optional 2:1 H/V decimation,
// RGB565 packing and active-area coordinates for the frame-buffer write side.
module hdmi_frame_decimator #(
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned DIV_W   = 4,
    parameter int unsigned H_W     = 12,
    parameter int unsigned V_W     = 12
) (
    input  logic               hdmi_pix_clk_in,
    input  logic               rst,
    input  logic [COLOR_W-1:0] red_in,
    input  logic [COLOR_W-1:0] green_in,
    input  logic [COLOR_W-1:0] blue_in,
    input  logic               vs_in,
    input  logic               de_in,
    input  logic [DIV_W-1:0]   frame_div,
    input  logic               scale_en,
    output logic               vs_out,
    output logic               de_out,
    output logic [15:0]        rgb565_out,
    output logic [H_W-1:0]     x_out,
    output logic [V_W-1:0]     y_out,
    output logic               frame_start
);

    // Stage 1
    logic             vs_d_q, vs_d_d;
    logic             de_d_q, de_d_d;
    logic [15:0]      rgb_d_q, rgb_d_d;
    logic [H_W-1:0]   xi_q, xi_d;
    logic [V_W-1:0]   yi_q, yi_d;
    logic [DIV_W-1:0] fcnt_q, fcnt_d;
    logic [DIV_W-1:0] div_s_q, div_s_d;
    logic             scale_s_q, scale_s_d;
    logic             keep_q, keep_d;
    logic             fs_pend_q, fs_pend_d;

    // Stage 2
    logic             vs_out_q, vs_out_d;
    logic             de_out_q, de_out_d;
    logic [15:0]      rgb565_q, rgb565_d;
    logic [H_W-1:0]   x_out_q, x_out_d;
    logic [V_W-1:0]   y_out_q, y_out_d;
    logic             frame_start_q, frame_start_d;

    logic             vs_rise;
    logic             de_fall;
    logic             pk;
    logic             unused_color_lsbs;

    always_comb begin
        unused_color_lsbs = &{1'b0, red_in, green_in, blue_in};
    end

    always_comb begin
        vs_rise = vs_in & ~vs_d_q;
        de_fall = ~de_in & de_d_q;

        vs_d_d  = vs_in;
        de_d_d  = de_in;
        rgb_d_d = {red_in[COLOR_W-1 -: 5], green_in[COLOR_W-1 -: 6], blue_in[COLOR_W-1 -: 5]};

        div_s_d   = div_s_q;
        scale_s_d = scale_s_q;
        keep_d    = keep_q;
        fcnt_d    = fcnt_q;
        if (vs_rise) begin
            div_s_d   = frame_div;
            scale_s_d = scale_en;
            keep_d    = (fcnt_q == '0);
            fcnt_d    = (fcnt_q >= div_s_d) ? '0 : fcnt_q + DIV_W'(1);
        end

        xi_d = xi_q;
        if (de_fall) begin
            xi_d = '0;
        end else if (de_d_q && (xi_q != '1)) begin
            xi_d = xi_q + H_W'(1);
        end

        yi_d = yi_q;
        if (vs_rise) begin
            yi_d = '0;
        end else if (de_fall && (yi_q != '1)) begin
            yi_d = yi_q + V_W'(1);
        end

        // Uses the pre-update keep/scale, so a pixel coinciding with vs_rise belongs to the old frame
        pk = keep_q & de_d_q & (~scale_s_q | (~xi_q[0] & ~yi_q[0]));

        de_out_d = pk;
        rgb565_d = '0;
        x_out_d  = '0;
        y_out_d  = '0;
        if (pk) begin
            rgb565_d = rgb_d_q;
            x_out_d  = scale_s_q ? (xi_q >> 1) : xi_q;
            y_out_d  = scale_s_q ? (yi_q >> 1) : yi_q;
        end

        vs_out_d = vs_d_q;
        // Held one extra cycle so the pulse rises together with vs_out
        fs_pend_d     = vs_rise & (fcnt_q == '0);
        frame_start_d = fs_pend_q;
    end

    always_ff @(posedge hdmi_pix_clk_in) begin
        if (!rst) begin
            vs_d_q        <= 1'b0;
            de_d_q        <= 1'b0;
            rgb_d_q       <= '0;
            xi_q          <= '0;
            yi_q          <= '0;
            fcnt_q        <= '0;
            div_s_q       <= '0;
            scale_s_q     <= 1'b0;
            keep_q        <= 1'b0;
            fs_pend_q     <= 1'b0;
            vs_out_q      <= 1'b0;
            de_out_q      <= 1'b0;
            rgb565_q      <= '0;
            x_out_q       <= '0;
            y_out_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            vs_d_q        <= vs_d_d;
            de_d_q        <= de_d_d;
            rgb_d_q       <= rgb_d_d;
            xi_q          <= xi_d;
            yi_q          <= yi_d;
            fcnt_q        <= fcnt_d;
            div_s_q       <= div_s_d;
            scale_s_q     <= scale_s_d;
            keep_q        <= keep_d;
            fs_pend_q     <= fs_pend_d;
            vs_out_q      <= vs_out_d;
            de_out_q      <= de_out_d;
            rgb565_q      <= rgb565_d;
            x_out_q       <= x_out_d;
            y_out_q       <= y_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        vs_out      = vs_out_q;
        de_out      = de_out_q;
        rgb565_out  = rgb565_q;
        x_out       = x_out_q;
        y_out       = y_out_q;
        frame_start = frame_start_q;
    end

endmodule

// File: tb/tb_hdmi_frame_decimator.sv
// Bench for hdmi_frame_decimator: frame-level reference model with a per-cycle scoreboard.
module tb_hdmi_frame_decimator;

    localparam int CW   = 8;
    localparam int DW   = 4;
    localparam int HW   = 12;
    localparam int VW   = 12;
    localparam int XMAX = (1 << HW) - 1;
    localparam int YMAX = (1 << VW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] red_in, green_in, blue_in;
    logic          vs_in, de_in;
    logic [DW-1:0] frame_div;
    logic          scale_en;
    logic          vs_out, de_out, frame_start;
    logic [15:0]   rgb565_out;
    logic [HW-1:0] x_out;
    logic [VW-1:0] y_out;

    hdmi_frame_decimator #(.COLOR_W(CW), .DIV_W(DW), .H_W(HW), .V_W(VW)) dut (
        .hdmi_pix_clk_in(clk),
        .rst(rst),
        .red_in(red_in),
        .green_in(green_in),
        .blue_in(blue_in),
        .vs_in(vs_in),
        .de_in(de_in),
        .frame_div(frame_div),
        .scale_en(scale_en),
        .vs_out(vs_out),
        .de_out(de_out),
        .rgb565_out(rgb565_out),
        .x_out(x_out),
        .y_out(y_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;
    int pix_count = 0;
    int fs_count = 0;

    typedef struct {
        int x;
        int y;
        int rgb;
    } exp_t;

    exp_t exp_q[int];
    bit   exp_fs[int];
    bit   vs_hist[int];
    bit   rst_hist[int];

    // Frame-level model state
    int m_fc;
    bit m_keep;
    bit m_scale;

    bit fix_en = 0;
    int fix_r, fix_g, fix_b;

    typedef struct {
        int div;
        bit scale;
        int w;
        int h;
        int frames;
        int exp_pix;
        int exp_fs;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int rgb565(int r, int g, int b);
        return ((r >> (CW - 5)) << 11) | ((g >> (CW - 6)) << 5) | (b >> (CW - 5));
    endfunction

    int mc;
    bit e_vs;
    always @(negedge clk) begin
        if (chk_en) begin
            mc   = cyc;
            e_vs = vs_hist.exists(mc - 2) ? vs_hist[mc - 2] : 1'b0;
            if (rst_hist.exists(mc - 1) || rst_hist.exists(mc - 2)) e_vs = 1'b0;
            chk("vs_out", vs_out, e_vs);
            chk("frame_start", frame_start, exp_fs.exists(mc));
            if (exp_q.exists(mc)) begin
                chk("de_out", de_out, 1);
                chk("x_out", x_out, exp_q[mc].x);
                chk("y_out", y_out, exp_q[mc].y);
                chk("rgb565_out", rgb565_out, exp_q[mc].rgb);
            end else begin
                chk("de_out_idle", de_out, 0);
                chk("rgb565_idle", rgb565_out, 0);
                chk("x_idle", x_out, 0);
                chk("y_idle", y_out, 0);
            end
            pix_count += int'(de_out);
            fs_count  += int'(frame_start);
        end
    end

    task automatic drive(bit v, bit de, int r, int g, int b, bit rn, output int d);
        @(posedge clk);
        #1;
        vs_in    = v;
        de_in    = de;
        red_in   = r[CW-1:0];
        green_in = g[CW-1:0];
        blue_in  = b[CW-1:0];
        rst      = rn;
        d        = cyc;
        vs_hist[d] = v;
        if (!rn) begin
            // Reset drops the frame and empties the pipeline
            rst_hist[d] = 1'b1;
            m_keep = 1'b0;
            m_fc   = 0;
            exp_q.delete(d + 1);
            exp_fs.delete(d + 1);
            exp_fs.delete(d + 2);
        end
    endtask

    task automatic do_reset();
        int d;
        drive(0, 0, 0, 0, 0, 0, d);
        drive(0, 0, 0, 0, 0, 0, d);
        drive(0, 0, 0, 0, 0, 1, d);
    endtask

    task automatic send_frame(int w, int h, int mid_pix, int mid_div, int mid_scale, int rst_at);
        int d, pix, r, g, b, xs, ys;
        drive(1, 0, 0, 0, 0, 1, d);
        m_scale = scale_en;
        m_keep  = (m_fc == 0);
        if (m_keep) exp_fs[d + 2] = 1'b1;
        m_fc = (m_fc >= int'(frame_div)) ? 0 : m_fc + 1;
        drive(1, 0, 0, 0, 0, 1, d);
        drive(0, 0, 0, 0, 0, 1, d);
        drive(0, 0, 0, 0, 0, 1, d);
        pix = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (pix == mid_pix) begin
                    if (mid_div >= 0) frame_div = mid_div[DW-1:0];
                    if (mid_scale >= 0) scale_en = mid_scale[0];
                end
                if (fix_en) begin
                    r = fix_r; g = fix_g; b = fix_b;
                end else begin
                    r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
                end
                drive(0, 1, r, g, b, pix != rst_at, d);
                if (m_keep) begin
                    xs = (x > XMAX) ? XMAX : x;
                    ys = (y > YMAX) ? YMAX : y;
                    if (!m_scale || ((xs % 2 == 0) && (ys % 2 == 0)))
                        exp_q[d + 2] = '{x: m_scale ? xs / 2 : xs, y: m_scale ? ys / 2 : ys, rgb: rgb565(r, g, b)};
                end
                pix++;
            end
            repeat (3) drive(0, 0, 0, 0, 0, 1, d);
        end
        repeat (2) drive(0, 0, 0, 0, 0, 1, d);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    int p0, f0, w, h, mp, md, ms, ra;

    initial begin
        tbl[0] = '{div: 0, scale: 0, w: 8,    h: 4, frames: 4, exp_pix: 128,  exp_fs: 4};
        tbl[1] = '{div: 2, scale: 0, w: 8,    h: 4, frames: 7, exp_pix: 96,   exp_fs: 3};
        tbl[2] = '{div: 0, scale: 1, w: 8,    h: 4, frames: 2, exp_pix: 16,   exp_fs: 2};
        tbl[3] = '{div: 1, scale: 0, w: 4,    h: 2, frames: 4, exp_pix: 16,   exp_fs: 2};
        tbl[4] = '{div: 3, scale: 1, w: 6,    h: 6, frames: 5, exp_pix: 18,   exp_fs: 2};
        tbl[5] = '{div: 0, scale: 0, w: 4100, h: 1, frames: 1, exp_pix: 4100, exp_fs: 1};

        rst = 0; vs_in = 0; de_in = 0; red_in = 0; green_in = 0; blue_in = 0;
        frame_div = 0; scale_en = 0;
        m_fc = 0; m_keep = 0; m_scale = 0;
        do_reset();
        chk_en = 1;

        @(negedge clk);
        chk("reset_de_out", de_out, 0);
        chk("reset_vs_out", vs_out, 0);
        chk("reset_frame_start", frame_start, 0);
        chk("reset_rgb", rgb565_out, 0);
        chk("reset_xy", {x_out, y_out}, 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            frame_div = tbl[i].div[DW-1:0];
            scale_en  = tbl[i].scale;
            p0 = pix_count; f0 = fs_count;
            for (int f = 0; f < tbl[i].frames; f++) send_frame(tbl[i].w, tbl[i].h, -1, -1, -1, -1);
            chk($sformatf("tbl%0d_pixels", i), pix_count - p0, tbl[i].exp_pix);
            chk($sformatf("tbl%0d_frame_starts", i), fs_count - f0, tbl[i].exp_fs);
        end

        // Fixed colour conversion
        do_reset();
        frame_div = 0; scale_en = 0;
        fix_en = 1; fix_r = 'hFF; fix_g = 'h80; fix_b = 'h0F;
        fork
            send_frame(1, 1, -1, -1, -1, -1);
            begin
                for (int k = 0; k < 40 && de_out !== 1'b1; k++) @(negedge clk);
                chk("fixed_pixel_seen", de_out, 1);
                chk("fixed_rgb565", rgb565_out, 16'hFC01);
            end
        join
        fix_en = 0;

        // Ratio change mid-frame takes effect at the next vs
        do_reset();
        frame_div = 0; scale_en = 0;
        p0 = pix_count;
        send_frame(8, 4, 12, 1, -1, -1);
        chk("middiv_cur_frame", pix_count - p0, 32);
        p0 = pix_count; f0 = fs_count;
        repeat (4) send_frame(8, 4, -1, -1, -1, -1);
        chk("middiv_next_frames", pix_count - p0, 64);
        chk("middiv_frame_starts", fs_count - f0, 2);

        // Reset mid-line of a kept frame
        do_reset();
        frame_div = 0; scale_en = 0;
        p0 = pix_count;
        send_frame(8, 4, -1, -1, -1, 10);
        chk("midreset_partial", pix_count - p0, 9);
        p0 = pix_count; f0 = fs_count;
        send_frame(8, 4, -1, -1, -1, -1);
        chk("midreset_next_frame", pix_count - p0, 32);
        chk("midreset_frame_start", fs_count - f0, 1);

        // Randomised frames against the model
        for (int i = 0; i < 16; i++) begin
            frame_div = $urandom_range(0, 3);
            scale_en  = $urandom_range(0, 1);
            w  = $urandom_range(1, 9);
            h  = $urandom_range(1, 5);
            mp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, w * h - 1) : -1;
            md = $urandom_range(0, 3);
            ms = $urandom_range(0, 1);
            ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w * h - 1) : -1;
            send_frame(w, h, mp, md, ms, ra);
        end

        repeat (4) @(posedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
